// File: rtl/div6_seq_ctrl.sv
// div6_seq_ctrl: start/done sequencer for a 6-bit restoring divider that borrows an external CLA adder.
// One quotient bit per iteration; each iteration holds the adder operands for ADD_WAIT+1 cycles.
module div6_seq_ctrl #(
    parameter int WIDTH    = 6,
    parameter int ADD_WAIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    localparam logic [2:0] K_LAST = 3'(WIDTH - 1);
    localparam logic [1:0] W_LAST = 2'(ADD_WAIT);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_dreg, r_vreg, r_rreg, r_quo, r_rem;
    logic [2:0]       r_k;
    logic [1:0]       r_wait;
    logic             r_dbz;
    logic             w_iter, w_last;
    logic [WIDTH-1:0] w_shift, w_new_r, w_new_d;

    assign w_iter  = r_state == ITER;
    assign w_last  = r_wait == W_LAST;
    assign w_shift = {r_rreg[WIDTH-2:0], r_dreg[WIDTH-1]};
    // add_cout doubles as the quotient bit: shift + ~v + 1 carries out exactly when shift >= v
    assign w_new_r = add_cout ? add_s : w_shift;
    assign w_new_d = {r_dreg[WIDTH-2:0], add_cout};

    assign busy        = r_state != IDLE;
    assign done        = r_state == DONE;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign add_a       = w_iter ? w_shift : '0;
    assign add_b       = w_iter ? ~r_vreg : '0;
    assign add_cin     = w_iter;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? ((divisor == '0) ? DONE : ITER) : IDLE;
            ITER:    w_next = (w_last && r_k == K_LAST) ? DONE : ITER;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dreg  <= '0;
            r_vreg  <= '0;
            r_rreg  <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_k     <= '0;
            r_wait  <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_dreg <= dividend;
                r_vreg <= divisor;
                r_rreg <= '0;
                r_k    <= '0;
                r_wait <= '0;
                r_dbz  <= divisor == '0;
                r_quo  <= (divisor == '0) ? '1 : '0;
                r_rem  <= (divisor == '0) ? dividend : '0;
            end else if (w_iter) begin
                r_wait <= w_last ? '0 : r_wait + 2'd1;
                if (w_last) begin
                    r_rreg <= w_new_r;
                    r_dreg <= w_new_d;
                    r_k    <= r_k + 3'd1;
                    if (r_k == K_LAST) begin
                        r_quo <= w_new_d;
                        r_rem <= w_new_r;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_div6_seq_ctrl.sv
// tb_div6_seq_ctrl: directed checks of the divider sequencer with a behavioural adder on each instance.
module tb_div6_seq_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       start0 = 1'b0, start2 = 1'b0;
    logic [5:0] dd0 = '0, dv0 = '0, dd2 = '0, dv2 = '0;
    logic       busy0, done0, dbz0, cin0, cout0, busy2, done2, dbz2, cin2, cout2;
    logic [5:0] q0, r0, a0, b0, s0, q2, r2, a2, b2, s2;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign {cout0, s0} = 7'(a0) + 7'(b0) + 7'(cin0);
    assign {cout2, s2} = 7'(a2) + 7'(b2) + 7'(cin2);

    div6_seq_ctrl #(.WIDTH(6), .ADD_WAIT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dividend(dd0), .divisor(dv0),
        .busy(busy0), .done(done0), .quotient(q0), .remainder(r0), .div_by_zero(dbz0),
        .add_a(a0), .add_b(b0), .add_cin(cin0), .add_s(s0), .add_cout(cout0));

    div6_seq_ctrl #(.WIDTH(6), .ADD_WAIT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dividend(dd2), .divisor(dv2),
        .busy(busy2), .done(done2), .quotient(q2), .remainder(r2), .div_by_zero(dbz2),
        .add_a(a2), .add_b(b2), .add_cin(cin2), .add_s(s2), .add_cout(cout2));

    // Pulses start for one cycle and returns on the negedge of the done cycle with lat = cycles after accept.
    task automatic run0(input logic [5:0] dd, input logic [5:0] dv, output int lat);
        @(negedge clk);
        dd0 = dd; dv0 = dv; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        lat = 1;
        while (!done0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy0, done0, q0, r0, dbz0, a0, b0, cin0} !== 30'd0)
            begin errors++; $display("FAIL reset_u0 got %h exp 0", {busy0, done0, q0, r0, dbz0, a0, b0, cin0}); end
        checks++;
        if ({busy2, done2, q2, r2, dbz2, a2, b2, cin2} !== 30'd0)
            begin errors++; $display("FAIL reset_u2 got %h exp 0", {busy2, done2, q2, r2, dbz2, a2, b2, cin2}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy0, done0, q0, r0} !== 14'd0)
            begin errors++; $display("FAIL idle_after_reset got %h exp 0", {busy0, done0, q0, r0}); end
    endtask

    task automatic test_basic;
        int lat;
        run0(6'd45, 6'd7, lat);
        checks++; if (lat != 7) begin errors++; $display("FAIL basic_latency got %0d exp 7", lat); end
        checks++; if (q0 !== 6'd6) begin errors++; $display("FAIL basic_quotient got %0d exp 6", q0); end
        checks++; if (r0 !== 6'd3) begin errors++; $display("FAIL basic_remainder got %0d exp 3", r0); end
        checks++; if ({busy0, dbz0} !== 2'b10) begin errors++; $display("FAIL basic_busy_dbz got %b exp 10", {busy0, dbz0}); end
        @(negedge clk);
        checks++;
        if ({busy0, done0, a0, b0, cin0} !== 15'd0)
            begin errors++; $display("FAIL basic_idle_ports got %h exp 0", {busy0, done0, a0, b0, cin0}); end
        checks++;
        if ({q0, r0} !== {6'd6, 6'd3}) begin errors++; $display("FAIL basic_hold got %0d/%0d exp 6/3", q0, r0); end
    endtask

    task automatic test_wait2;
        int lat;
        @(negedge clk);
        dd2 = 6'd63; dv2 = 6'd1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        // 63/1: every shifted remainder is 1, so the adder sees 1 + ~1 + 1 for all 18 iteration cycles
        while (!done2 && lat < 100) begin
            checks++;
            if ({a2, b2, cin2} !== {6'd1, 6'd62, 1'b1})
                begin errors++; $display("FAIL wait2_operands cycle %0d got %h exp %h", lat, {a2, b2, cin2}, {6'd1, 6'd62, 1'b1}); end
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 19) begin errors++; $display("FAIL wait2_latency got %0d exp 19", lat); end
        checks++; if ({q2, r2} !== {6'd63, 6'd0}) begin errors++; $display("FAIL wait2_result got %0d/%0d exp 63/0", q2, r2); end
        @(negedge clk);
        dd2 = 6'd45; dv2 = 6'd7; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 19) begin errors++; $display("FAIL wait2_latency2 got %0d exp 19", lat); end
        checks++; if ({q2, r2} !== {6'd6, 6'd3}) begin errors++; $display("FAIL wait2_result2 got %0d/%0d exp 6/3", q2, r2); end
    endtask

    task automatic test_boundary;
        int tv[4][4] = '{'{5, 9, 0, 5}, '{63, 63, 1, 0}, '{0, 13, 0, 0}, '{63, 32, 1, 31}};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run0(6'(tv[i][0]), 6'(tv[i][1]), lat);
            checks++;
            if ({q0, r0} !== {6'(tv[i][2]), 6'(tv[i][3])} || lat != 7)
                begin errors++; $display("FAIL boundary_%0d_%0d got q%0d r%0d lat%0d exp q%0d r%0d lat7", tv[i][0], tv[i][1], q0, r0, lat, tv[i][2], tv[i][3]); end
        end
    endtask

    task automatic test_div_zero;
        int lat;
        run0(6'd17, 6'd0, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency got %0d exp 1", lat); end
        checks++;
        if ({dbz0, q0, r0} !== {1'b1, 6'd63, 6'd17})
            begin errors++; $display("FAIL dbz_result got %b q%0d r%0d exp 1 q63 r17", dbz0, q0, r0); end
        @(negedge clk);
        checks++; if ({busy0, dbz0} !== 2'b01) begin errors++; $display("FAIL dbz_hold got %b exp 01", {busy0, dbz0}); end
        run0(6'd45, 6'd7, lat);
        checks++;
        if ({dbz0, q0, r0} !== {1'b0, 6'd6, 6'd3})
            begin errors++; $display("FAIL dbz_clear got %b q%0d r%0d exp 0 q6 r3", dbz0, q0, r0); end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        dd0 = 6'd45; dv0 = 6'd7; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        lat = 1;
        while (!done0 && lat < 100) begin
            start0 = lat == 3;
            if (lat == 3) begin dd0 = 6'd20; dv0 = 6'd3; end
            @(negedge clk);
            lat++;
        end
        start0 = 1'b0;
        checks++;
        if ({q0, r0} !== {6'd6, 6'd3} || lat != 7)
            begin errors++; $display("FAIL ignore_start got q%0d r%0d lat%0d exp q6 r3 lat7", q0, r0, lat); end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        dd0 = 6'd45; dv0 = 6'd7; start0 = 1'b1;
        @(negedge clk);
        dd0 = 6'd20; dv0 = 6'd3;
        lat = 1;
        while (!done0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if ({q0, r0} !== {6'd6, 6'd3} || lat != 7)
            begin errors++; $display("FAIL b2b_first got q%0d r%0d lat%0d exp q6 r3 lat7", q0, r0, lat); end
        @(negedge clk);
        checks++; if ({busy0, done0} !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b exp 00", {busy0, done0}); end
        @(negedge clk);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", busy0); end
        start0 = 1'b0;
        lat = 1;
        while (!done0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if ({q0, r0} !== {6'd6, 6'd2} || lat != 7)
            begin errors++; $display("FAIL b2b_second got q%0d r%0d lat%0d exp q6 r2 lat7", q0, r0, lat); end
    endtask

    task automatic test_reset_mid;
        int  lat;
        logic seen;
        @(negedge clk);
        dd0 = 6'd45; dv0 = 6'd7; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy0, done0, q0, r0, dbz0, a0, b0, cin0} !== 30'd0)
            begin errors++; $display("FAIL reset_mid got %h exp 0", {busy0, done0, q0, r0, dbz0, a0, b0, cin0}); end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | done0 | busy0;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_done got %b exp 0", seen); end
        run0(6'd45, 6'd7, lat);
        checks++;
        if ({q0, r0} !== {6'd6, 6'd3} || lat != 7)
            begin errors++; $display("FAIL reset_mid_fresh got q%0d r%0d lat%0d exp q6 r3 lat7", q0, r0, lat); end
    endtask

    task automatic test_sweep;
        int lat;
        for (int d = 0; d < 64; d++)
            for (int v = 1; v < 64; v++) begin
                run0(6'(d), 6'(v), lat);
                checks++;
                if ({q0, r0} !== {6'(d / v), 6'(d % v)} || lat != 7)
                    begin errors++; $display("FAIL sweep_%0d_%0d got q%0d r%0d lat%0d exp q%0d r%0d lat7", d, v, q0, r0, lat, d / v, d % v); end
            end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wait2;
        test_boundary;
        test_div_zero;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
